// File: rtl/sw_seq_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : sw_seq_feeder
//  Description : Read side of the DNA base FIFO. Drains seq_len encoded bases
//                per job and streams them, in order, to the Smith-Waterman PE
//                array over valid/ready. A 3-entry skid buffer absorbs the
//                FIFO's 1-cycle read latency and downstream backpressure.
//                Each beat carries its 0-based index and a last flag; done
//                pulses for one cycle when the job finishes.
//  Ports       : clk, reset      - clock (rising edge), async active-high reset
//                start, seq_len  - job request and length, sampled while idle
//                fifo_empty      - base FIFO has no readable entry
//                fifo_rd         - FIFO read strobe
//                fifo_rdata      - FIFO data, valid the cycle after fifo_rd
//                out_valid/out_ready/out_base/out_idx/out_last - PE stream
//                busy            - job in progress
//                done            - one-cycle job-finished pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_seq_feeder #(
    parameter int BASE_W = 2,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  seq_len,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [BASE_W-1:0] fifo_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BASE_W-1:0] out_base,
    output logic [LEN_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIN  = 2'd2;

    localparam logic [2:0] c_SKID_DEPTH = 3'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_start_run;

    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_fetch_cnt;
    logic [LEN_W-1:0]  r_beat_cnt;

    logic              r_rd_d;      // a read was issued last cycle: data lands now
    logic [1:0]        r_occ;       // entries held in the skid buffer
    logic [1:0]        w_occ_nxt;
    logic [1:0]        w_wr_idx;
    logic              r_valid;

    logic [BASE_W-1:0] r_buf0;      // head of the skid buffer
    logic [BASE_W-1:0] r_buf1;
    logic [BASE_W-1:0] r_buf2;

    logic              w_push;
    logic              w_pop;
    logic              w_is_last;
    logic              w_last_beat;
    logic [2:0]        w_reserved;

    // Slots already committed: entries held plus the one still in flight
    // from the FIFO. A read is only issued if its data is guaranteed a slot,
    // so the decision never has to look at out_ready.
    assign w_reserved = {1'b0, r_occ} + {2'b00, r_rd_d};

    assign fifo_rd = (r_state == c_RUN) && !fifo_empty &&
                     (r_fetch_cnt < r_len) && (w_reserved < c_SKID_DEPTH);

    assign w_push      = r_rd_d;
    assign w_pop       = r_valid && out_ready;
    assign w_is_last   = (r_beat_cnt == r_len - LEN_W'(1));
    assign w_last_beat = w_pop && w_is_last;

    assign w_occ_nxt = r_occ + {1'b0, w_push} - {1'b0, w_pop};
    // On a simultaneous pop the entries shift down first, so the new data
    // goes one slot lower than the current occupancy.
    assign w_wr_idx  = r_occ - {1'b0, w_pop};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start_run = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    if (seq_len != '0) begin
                        w_state_nxt = c_RUN;
                        w_start_run = 1'b1;
                    end else begin
                        // Empty job: nothing to fetch, report completion.
                        w_state_nxt = c_FIN;
                    end
                end
            end
            c_RUN: begin
                busy = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = c_FIN;
                end
            end
            c_FIN: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Job length and fetch/beat counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len       <= '0;
            r_fetch_cnt <= '0;
            r_beat_cnt  <= '0;
            r_rd_d      <= 1'b0;
        end else begin
            r_rd_d <= fifo_rd;
            if (w_start_run) begin
                r_len       <= seq_len;
                r_fetch_cnt <= '0;
                r_beat_cnt  <= '0;
            end else begin
                if (fifo_rd) begin
                    r_fetch_cnt <= r_fetch_cnt + LEN_W'(1);
                end
                if (w_pop) begin
                    r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer: shift-down storage, head always in r_buf0
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf0  <= '0;
            r_buf1  <= '0;
            r_buf2  <= '0;
            r_occ   <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            r_occ   <= w_occ_nxt;
            r_valid <= (w_occ_nxt != 2'd0);
            if (w_pop) begin
                r_buf0 <= r_buf1;
                r_buf1 <= r_buf2;
            end
            // Placed after the shift so an incoming base overrides the
            // shifted value in its slot.
            if (w_push) begin
                case (w_wr_idx)
                    2'd0:    r_buf0 <= fifo_rdata;
                    2'd1:    r_buf1 <= fifo_rdata;
                    default: r_buf2 <= fifo_rdata;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output beat; sideband forced to zero while no beat is offered
    // ------------------------------------------------------------------
    assign out_valid = r_valid;
    assign out_base  = r_valid ? r_buf0 : '0;
    assign out_idx   = r_valid ? r_beat_cnt : '0;
    assign out_last  = r_valid && w_is_last;

endmodule
`default_nettype wire
